// File: rtl/con_pkg.sv
// rtl/con_pkg.sv - shared widths and accumulator state type for the conv MAC
package con_pkg;
    localparam int DW     = 8;
    localparam int PE_NUM = 9;
    localparam int PROD_W = 16;
    localparam int ROW_W  = 18;
    localparam int SUM_W  = 20;
    localparam int ACC_W  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;
endpackage

// File: rtl/con_mac_row.sv
// rtl/con_mac_row.sv - one window row: three registered products, then a registered row sum
module con_mac_row
    import con_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [3*DW-1:0]   data_i,
    input  logic [3*DW-1:0]   wt_i,
    output logic [ROW_W-1:0]  row_sum_o
);

    logic [PROD_W-1:0] prod_q [3];
    logic [ROW_W-1:0]  row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= '0;
            end
            row_q <= '0;
        end else if (en_i) begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= PROD_W'(data_i[(2-i)*DW +: DW]) * PROD_W'(wt_i[(2-i)*DW +: DW]);
            end
            row_q <= ROW_W'(prod_q[0]) + ROW_W'(prod_q[1]) + ROW_W'(prod_q[2]);
        end
    end

    assign row_sum_o = row_q;

endmodule

// File: rtl/con_mac.sv
// rtl/con_mac.sv - 3x3 window MAC: multiply/row/window pipeline plus CH_NUM-window accumulator
module con_mac
    import con_pkg::*;
#(
    parameter int CH_NUM = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PE_NUM*DW-1:0] data_pe,
    input  logic [PE_NUM*DW-1:0] wt_pe,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     result,
    output logic [3:0]           ch_cnt
);

    localparam logic [3:0] LAST_CH = 4'(CH_NUM - 1);

    logic              en;
    logic              v1_q, v2_q, v3_q;
    logic [ROW_W-1:0]  row_sum [3];
    logic [SUM_W-1:0]  win_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q;
    logic [3:0]        ch_cnt_q;
    logic              out_valid_q;
    acc_state_e        state_q;

    // The whole pipeline stalls together whenever a result is waiting unread.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    for (genvar r = 0; r < 3; r++) begin : g_row
        con_mac_row u_row (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en),
            .data_i    (data_pe[(2-r)*3*DW +: 3*DW]),
            .wt_i      (wt_pe[(2-r)*3*DW +: 3*DW]),
            .row_sum_o (row_sum[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else if (flush) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else if (en) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (en) begin
            win_q <= SUM_W'(row_sum[0]) + SUM_W'(row_sum[1]) + SUM_W'(row_sum[2]);
        end
    end

    assign acc_d = (state_q == IDLE) ? ACC_W'(win_q) : acc_q + ACC_W'(win_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            // With en high any pending result is being consumed this cycle.
            out_valid_q <= 1'b0;
            if (v3_q) begin
                acc_q <= acc_d;
                if (ch_cnt_q == LAST_CH) begin
                    state_q     <= IDLE;
                    ch_cnt_q    <= '0;
                    result_q    <= acc_d;
                    out_valid_q <= 1'b1;
                end else begin
                    state_q  <= ACC;
                    ch_cnt_q <= ch_cnt_q + 4'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ch_cnt    = ch_cnt_q;

endmodule

// File: tb/tb_con_mac.sv
// tb/tb_con_mac.sv - self-checking bench for con_mac with CH_NUM = 1, 3 and 16
module tb_con_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [71:0] data_pe, wt_pe;
    logic        out_ready;
    logic [2:0]  iv, fl, ir, ov;
    logic [23:0] res0, res1, res2;
    logic [3:0]  cc0, cc1, cc2;

    always #5 clk = ~clk;

    con_mac #(.CH_NUM(1)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_pe(data_pe), .wt_pe(wt_pe), .flush(fl[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .result(res0), .ch_cnt(cc0));
    con_mac #(.CH_NUM(3)) u_ch3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_pe(data_pe), .wt_pe(wt_pe), .flush(fl[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .result(res1), .ch_cnt(cc1));
    con_mac #(.CH_NUM(16)) u_ch16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_pe(data_pe), .wt_pe(wt_pe), .flush(fl[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .result(res2), .ch_cnt(cc2));

    typedef struct {
        logic [71:0] d;
        logic [71:0] w;
        int unsigned e;
    } vec_t;

    vec_t        tbl[7];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned q0[$], q1[$], q2[$];
    int unsigned macc[3];
    int          mcnt[3];

    function automatic int ch_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input int unsigned v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic model_accept(input int k, input int unsigned ew);
        macc[k] = (mcnt[k] == 0) ? ew : macc[k] + ew;
        mcnt[k]++;
        if (mcnt[k] == ch_of(k)) begin
            push_exp(k, macc[k]);
            mcnt[k] = 0;
        end
    endtask

    task automatic model_clear(input int k);
        mcnt[k] = 0;
        macc[k] = 0;
    endtask

    task automatic send(input int k, input logic [71:0] d, input logic [71:0] w, input int unsigned ew);
        bit took = 1'b0;
        data_pe = d;
        wt_pe   = w;
        iv      = 3'(1 << k);
        for (int b = 0; b < 50 && !took; b++) begin
            @(negedge clk);
            took = ir[k];
            @(posedge clk);
            #1;
        end
        iv = 3'b000;
        if (took) model_accept(k, ew);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: inst %0d got no in_ready expected in_ready=1", k);
        end
    endtask

    task automatic pop_chk(input int k, input logic [23:0] act);
        int unsigned e;
        bit          empty;
        case (k)
            0:       begin empty = (q0.size() == 0); if (!empty) e = q0.pop_front(); end
            1:       begin empty = (q1.size() == 0); if (!empty) e = q1.pop_front(); end
            default: begin empty = (q2.size() == 0); if (!empty) e = q2.pop_front(); end
        endcase
        if (empty) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: inst %0d got result %0d expected no out_valid", k, act);
        end else begin
            chk($sformatf("result_inst%0d", k), 32'(act), e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready) begin
            if (ov[0]) pop_chk(0, res0);
            if (ov[1]) pop_chk(1, res1);
            if (ov[2]) pop_chk(2, res2);
        end
    end

    task automatic drain();
        for (int b = 0; b < 300; b++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && ov == 3'b000) break;
            @(posedge clk);
            #1;
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
    endtask

    initial begin
        tbl[0] = '{{9{8'd1}},   {9{8'd1}},   9};
        tbl[1] = '{{9{8'd255}}, {9{8'd255}}, 585225};
        tbl[2] = '{72'd0,       {9{8'd255}}, 0};
        tbl[3] = '{{8'd200, 64'd0}, {8'd100, 64'd0}, 20000};
        tbl[4] = '{{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                   {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 165};
        tbl[5] = '{{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255},
                   {9{8'd255}}, 325125};
        tbl[6] = '{72'd7, 72'd6, 42};

        for (int k = 0; k < 3; k++) model_clear(k);
        rst_n = 1'b0; iv = 3'b000; fl = 3'b000; out_ready = 1'b1;
        data_pe = '0; wt_pe = '0;

        @(negedge clk);
        chk("rst_in_ready", 32'(ir), 3'b111);
        chk("rst_out_valid", 32'(ov), 3'b000);
        chk("rst_result1", res1, 0);
        chk("rst_ch_cnt1", cc1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(ir), 3'b111);

        // Single window, CH_NUM=1: result visible exactly four cycles after acceptance
        send(0, {9{8'd1}}, {9{8'd1}}, 9);
        chk("lat_n1", ov[0], 0);
        @(posedge clk); #1; chk("lat_n2", ov[0], 0);
        @(posedge clk); #1; chk("lat_n3", ov[0], 0);
        @(posedge clk); #1; chk("lat_n4", ov[0], 1);
        chk("lat_result", res0, 9);
        @(posedge clk); #1; chk("lat_drop", ov[0], 0);

        foreach (tbl[i]) send(0, tbl[i].d, tbl[i].w, tbl[i].e);
        drain();

        for (int i = 0; i < 16; i++) send(2, {9{8'd255}}, {9{8'd255}}, 585225);
        drain();
        chk("ch16_max", res2, 9363600);

        // CH_NUM=3 group 9+18+27 with ch_cnt stepping 1, 2, 0
        send(1, {9{8'd1}}, {9{8'd1}}, 9);
        send(1, {9{8'd1}}, {9{8'd2}}, 18);
        send(1, {9{8'd1}}, {9{8'd3}}, 27);
        @(posedge clk); #1; chk("cc_seq1", cc1, 1);
        @(posedge clk); #1; chk("cc_seq2", cc1, 2);
        @(posedge clk); #1; chk("cc_seq0", cc1, 0);
        chk("grp_valid", ov[1], 1);
        drain();

        // Back-pressure while the stream keeps offering windows
        out_ready = 1'b0;
        fork
            begin
                for (int g = 1; g <= 3; g++)
                    for (int i = 0; i < 3; i++)
                        send(1, {9{8'd1}}, {9{8'(g)}}, 9 * g);
            end
            begin
                for (int b = 0; b < 30 && !ov[1]; b++) begin
                    @(posedge clk); #1;
                end
                for (int c = 0; c < 5; c++) begin
                    chk("stall_valid", ov[1], 1);
                    chk("stall_in_ready", ir[1], 0);
                    chk("stall_result", res1, 27);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush discards a partial accumulation and a concurrently offered window
        send(1, {9{8'd1}}, {9{8'd2}}, 18);
        send(1, {9{8'd1}}, {9{8'd2}}, 18);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_flush_cc", cc1, 2);
        data_pe = {9{8'd1}}; wt_pe = {9{8'd1}};
        iv = 3'b010; fl = 3'b010;
        @(posedge clk); #1;
        iv = 3'b000; fl = 3'b000;
        model_clear(1);
        chk("flush_cc", cc1, 0);
        chk("flush_valid", ov[1], 0);
        send(1, {9{8'd1}}, {9{8'd5}}, 45);
        fl = 3'b010;
        @(posedge clk); #1;
        fl = 3'b000;
        model_clear(1);
        for (int i = 0; i < 3; i++) send(1, {9{8'd1}}, {9{8'd1}}, 9);
        drain();

        // Reset pulse with three windows in flight
        for (int i = 0; i < 3; i++) send(1, {9{8'd1}}, {9{8'd4}}, 36);
        rst_n = 1'b0;
        model_clear(1);
        q1.delete();
        #1;
        chk("mid_rst_valid", 32'(ov), 3'b000);
        chk("mid_rst_result0", res0, 0);
        chk("mid_rst_result1", res1, 0);
        chk("mid_rst_cc1", cc1, 0);
        chk("mid_rst_in_ready", 32'(ir), 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("post_rst_quiet", ov[1], 0);
        chk("post_rst_cc", cc1, 0);
        for (int i = 0; i < 3; i++) send(1, {9{8'd1}}, {9{8'd1}}, 9);
        drain();
        chk("post_rst_result", res1, 27);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/con_mac.md
CON_MAC -- requirements
Module: con_mac

Interface
REQ-001 Parameter CH_NUM, default 3: number of consecutive 3x3 windows (channels) accumulated into one result; legal range 1..16.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  the data_pe/wt_pe window is valid this cycle.
REQ-005 in_ready  out  1  block accepts a window this cycle; a transfer occurs when in_valid && in_ready.
REQ-006 data_pe  in  72  nine unsigned 8-bit pixels; PE0 is [71:64] and PE8 is [7:0]; row0 = PE0..2, row1 = PE3..5, row2 = PE6..8.
REQ-007 wt_pe  in  72  nine unsigned 8-bit weights, packed in the same order as data_pe.
REQ-008 flush  in  1  synchronous abort: discards in-flight windows and any partial accumulation.
REQ-009 out_valid  out  1  result holds a completed accumulation.
REQ-010 out_ready  in  1  consumer accepts result; a transfer occurs when out_valid && out_ready.
REQ-011 result  out  24  unsigned sum of CH_NUM window dot-products.
REQ-012 ch_cnt  out  4  number of windows already accumulated toward the current result (0..CH_NUM-1).

Function
REQ-013 Global advance enable: en = !out_valid || out_ready; in_ready shall equal en.
REQ-014 Every pipeline register shall update only when en=1; when en=0, all state shall hold (full stall, no bubbles lost).
REQ-015 Stage S1: register nine 16-bit products data_pe[i]*wt_pe[i], plus v1 = in_valid && en.
REQ-016 Stage S2: register three 18-bit row sums (PE0..2, PE3..5, PE6..8), plus v2 = v1.
REQ-017 Stage S3: register one 20-bit window sum of the three row sums, plus v3 = v2.
REQ-018 Accumulate stage, on v3 && en: if ch_cnt==0, acc <= window sum, else acc <= acc + window sum.
REQ-019 In the same accumulate-stage update, if ch_cnt==CH_NUM-1: result <= final sum, out_valid <= 1, ch_cnt <= 0; otherwise ch_cnt <= ch_cnt+1.
REQ-020 Latency: with out_ready=1, the final window of a group accepted at cycle N shall produce out_valid=1 at cycle N+4.
REQ-021 Throughput is one window per cycle while out_ready=1; back-to-back groups need no idle cycle.
REQ-022 Output handshake: if out_valid && out_ready and no completion occurs in that cycle, out_valid <= 0.
REQ-023 If out_valid && out_ready and a completion occurs in the same cycle, result is replaced and out_valid stays 1.
REQ-024 While out_valid && !out_ready, result and out_valid shall hold stable.
REQ-025 Widths: products 16 b, row sums 18 b, window sum 20 b (max 585225), accumulator 24 b (max 16*585225 = 9363600); no truncation and no overflow are possible.
REQ-026 flush=1 clears v1, v2, v3, acc, ch_cnt and out_valid on the next edge regardless of en; result keeps its last value.
REQ-027 flush has priority over a simultaneous in_valid transfer; that window is discarded.
REQ-028 Accumulator state machine: IDLE (ch_cnt=0, acc invalid) -> ACC on first v3; ACC -> IDLE on completion; any state -> IDLE on flush.

Reset
REQ-029 On rst_n=0, asynchronously: v1=v2=v3=0, acc=0, ch_cnt=0, out_valid=0, result=0, and S1..S3 data registers=0.
REQ-030 Reset deasserting mid-operation shall restart cleanly; no pre-reset window shall contribute to any later result.
REQ-031 in_ready shall read 1 during and immediately after reset, since out_valid=0.

Structure
REQ-032 Shared package con_pkg shall hold DW=8, PE_NUM=9, PROD_W=16, ROW_W=18, SUM_W=20, ACC_W=24 and the state enum {IDLE, ACC}.
REQ-033 One sub-module, con_mac_row, shall implement three multipliers with registered products plus a registered row adder; it shall be instantiated three times.
REQ-034 The S3 adder, accumulator, FSM and handshake logic shall remain in con_mac.

Verification
REQ-035 CH_NUM=1; all data=1, all wt=1, in_valid for one cycle -> out_valid at N+4 with result=9.
REQ-036 CH_NUM=1; all data=255, all wt=255 -> result=585225; then CH_NUM=16 with 16 such windows -> result=9363600.
REQ-037 CH_NUM=3; three back-to-back windows with sums 9, 18, 27 -> one out_valid pulse with result=54, ch_cnt sequence 1, 2, 0.
REQ-038 out_ready=0 when a result completes -> in_ready=0 and result held 5 cycles; out_ready=1 -> transfer, stream resumes with no window lost or duplicated.
REQ-039 CH_NUM=3; flush after 2 windows, then 3 windows of sum 9 -> result=27 (partial data discarded).
REQ-040 rst_n pulsed low for 1 cycle mid-pipeline with 3 windows in flight -> all outputs 0, no out_valid until a fresh full group completes.
